// File: rtl/pulse_meas.sv
// pulse_meas: arm-triggered pulse measurement.
// After arm, counts low samples of din until its first high sample (delay),
// then counts the high samples (width). Both counts saturate at 2^width-1 and
// are reported with a one-cycle valid strobe. The delay counter saturating in
// WAIT_RISE ends the measurement with timeout set.
// Build option: define PULSE_MEAS_SYNC_EN to pass din through a 2-flop
// synchronizer. This allows an asynchronous din and adds 2 cycles to dly_out.
module pulse_meas #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             arm,
  input  logic             din,
  output logic             busy,
  output logic             valid,
  output logic [width-1:0] dly_out,
  output logic [width-1:0] len_out,
  output logic             timeout
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    HIGH      = 2'd2
  } state_t;

  localparam logic [width-1:0] cnt_max = '1;
  localparam logic [width-1:0] cnt_one = width'(1);

  state_t           state, state_nxt;
  logic [width-1:0] dly_cnt, dly_cnt_nxt;
  logic [width-1:0] len_cnt, len_cnt_nxt;
  logic             valid_nxt;
  logic             timeout_nxt;
  logic [width-1:0] dly_out_nxt, len_out_nxt;
  logic             s;

`ifdef PULSE_MEAS_SYNC_EN
  logic [1:0] sync_q;

  // Two-flop synchronizer. The sample point is the second flop.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sync_q <= 2'b00;
    else       sync_q <= {sync_q[0], din};
  end

  assign s = sync_q[1];
`else
  assign s = din;
`endif

  assign busy = (state != IDLE);

  // Next state, counter updates and the result registers, decided from the current state and s.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave a value unassigned and infer a latch.
    state_nxt   = state;
    dly_cnt_nxt = dly_cnt;
    len_cnt_nxt = len_cnt;
    valid_nxt   = 1'b0;
    timeout_nxt = timeout;
    dly_out_nxt = dly_out;
    len_out_nxt = len_out;
    unique case (state)
      IDLE: begin
        if (arm) begin
          state_nxt   = WAIT_RISE;
          dly_cnt_nxt = '0;
          len_cnt_nxt = '0;
        end
      end
      WAIT_RISE: begin
        if (s) begin
          state_nxt   = HIGH;
          len_cnt_nxt = cnt_one;
        end else if (dly_cnt == cnt_max) begin
          state_nxt   = IDLE;
          valid_nxt   = 1'b1;
          timeout_nxt = 1'b1;
          dly_out_nxt = cnt_max;
          len_out_nxt = '0;
        end else begin
          dly_cnt_nxt = dly_cnt + cnt_one;
        end
      end
      HIGH: begin
        if (s) begin
          if (len_cnt != cnt_max) len_cnt_nxt = len_cnt + cnt_one;
        end else begin
          state_nxt   = IDLE;
          valid_nxt   = 1'b1;
          timeout_nxt = 1'b0;
          dly_out_nxt = dly_cnt;
          len_out_nxt = len_cnt;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, counters and the registered result outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      dly_cnt <= '0;
      len_cnt <= '0;
      valid   <= 1'b0;
      timeout <= 1'b0;
      dly_out <= '0;
      len_out <= '0;
    end else begin
      // NOTE: non-blocking assignments, so every register samples values from before the edge.
      state   <= state_nxt;
      dly_cnt <= dly_cnt_nxt;
      len_cnt <= len_cnt_nxt;
      valid   <= valid_nxt;
      timeout <= timeout_nxt;
      dly_out <= dly_out_nxt;
      len_out <= len_out_nxt;
    end
  end

endmodule

// File: tb/tb_pulse_meas.sv
// Testbench for pulse_meas.
// Random and directed measurements are scored against a sample-sequence
// reference model. Expected results are queued when a measurement is armed.
// A negedge monitor pops and compares one entry on every valid strobe.
module tb_pulse_meas;

  localparam int W   = 8;
  localparam int MAX = (1 << W) - 1;
`ifdef PULSE_MEAS_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic         clk  = 1'b0;
  logic         rstn = 1'b0;
  logic         arm  = 1'b0;
  logic         din  = 1'b0;
  logic         busy;
  logic         valid;
  logic [W-1:0] dly_out;
  logic [W-1:0] len_out;
  logic         timeout;

  typedef struct {
    int dly;
    int len;
    int to;
  } exp_t;

  exp_t sb[$];
  bit   hist[$];   // din value presented at every posedge, in order
  int   n_vec = 0;
  int   n_err = 0;

  pulse_meas #(.width(W)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .arm     (arm),
    .din     (din),
    .busy    (busy),
    .valid   (valid),
    .dly_out (dly_out),
    .len_out (len_out),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Record the din that the coming edge sees, then move to 1 time unit past that edge.
  task automatic step();
    hist.push_back(din);
    @(posedge clk);
    #1;
  endtask

  // din at global edge idx for a measurement armed at edge a. The planned pattern after arm is d low, then l high, then low.
  function automatic bit din_at(int idx, int a, int d, int l);
    int j;
    if (idx <= a) return (idx >= 0) ? hist[idx] : 1'b0;
    j = idx - a;
    return (j > d) && (j <= d + l);
  endfunction

  // Reference model: the sample at edge k after arm is din from LAT edges earlier.
  // delay = number of samples before the first high, which must occur within MAX+1 samples;
  // len = length of the high run, capped at MAX.
  function automatic exp_t model(int a, int d, int l);
    exp_t e;
    int   r;
    int   run;
    r   = 0;
    run = 0;
    for (int k = 1; k <= MAX + 1; k++) begin
      if (din_at(a + k - LAT, a, d, l)) begin
        r = k;
        break;
      end
    end
    if (r == 0) begin
      e.dly = MAX;
      e.len = 0;
      e.to  = 1;
    end else begin
      while (run < MAX && din_at(a + r + run - LAT, a, d, l)) run++;
      e.dly = r - 1;
      e.len = run;
      e.to  = 0;
    end
    return e;
  endfunction

  // One measurement: gap idle cycles at level pre, arm, then drive the pattern until busy drops.
  // arm_mode: 0 = arm low while busy, 1 = random arm while busy, 2 = arm held high while busy.
  task automatic measure(input int gap, input bit pre, input int d, input int l, input int arm_mode);
    int a;
    int j;
    int guard;
    arm = 1'b0;
    for (int i = 0; i < gap; i++) begin
      din = pre;
      step();
    end
    arm = 1'b1;
    din = pre;
    step();
    a = hist.size() - 1;
    sb.push_back(model(a, d, l));
    check("busy_after_arm", int'(busy), 1);
    j     = 1;
    guard = 0;
    while (busy && guard < 2 * MAX + 40) begin
      din = din_at(a + j, a, d, l);
      case (arm_mode)
        1:       arm = ($urandom_range(0, 3) == 0);
        2:       arm = 1'b1;
        default: arm = 1'b0;
      endcase
      step();
      j++;
      guard++;
    end
    arm = 1'b0;
    check("measurement_ends", int'(busy), 0);
  endtask

  // Scoreboard monitor: each valid strobe consumes one expected result.
  always @(negedge clk) begin
    exp_t e;
    if (rstn && valid) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", int'(valid), 0);
      end else begin
        e = sb.pop_front();
        check("dly_out", int'(dly_out), e.dly);
        check("len_out", int'(len_out), e.len);
        check("timeout", int'(timeout), e.to);
        check("busy_with_valid", int'(busy), 0);
      end
    end
  end

  initial begin
    int  gap;
    bit  pre;
    int  d;
    int  l;

    // Values held while in reset.
    #2;
    check("rst_busy",    int'(busy),    0);
    check("rst_valid",   int'(valid),   0);
    check("rst_dly_out", int'(dly_out), 0);
    check("rst_len_out", int'(len_out), 0);
    check("rst_timeout", int'(timeout), 0);
    step();
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) step();

    // Directed cases.
    measure(2, 1'b0, 5, 3, 0);            // basic: delay 5, width 3
    measure(3, 1'b1, 0, 4, 0);            // din already high at arm
    measure(2, 1'b0, MAX + 3, 2, 0);      // delay counter saturates: timeout
    measure(0, 1'b0, 3, 2, 0);            // re-armed in the valid cycle after a timeout
    measure(2, 1'b0, 3, MAX + 5, 0);      // width saturates at MAX
    measure(2, 1'b0, MAX, 2, 0);          // rise on the last sample before timeout
    measure(2, 1'b0, 2, 10, 2);           // arm held high while busy is ignored
    measure(0, 1'b0, 4, 2, 0);            // back-to-back arm in the valid cycle

    // Reset in the middle of WAIT_RISE discards the measurement.
    arm = 1'b1;
    din = 1'b0;
    step();
    arm = 1'b0;
    step();
    step();
    check("busy_before_reset", int'(busy), 1);
    #2;
    rstn = 1'b0;
    #1;
    check("midrst_busy",    int'(busy),    0);
    check("midrst_valid",   int'(valid),   0);
    check("midrst_dly_out", int'(dly_out), 0);
    check("midrst_len_out", int'(len_out), 0);
    check("midrst_timeout", int'(timeout), 0);
    step();
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) step();
    measure(1, 1'b0, 6, 2, 0);            // a normal measurement after reset

    // Randomized measurements.
    for (int n = 0; n < 150; n++) begin
      gap = $urandom_range(0, 3);
      pre = 1'($urandom_range(0, 1));
      d   = ($urandom_range(0, 9) == 0) ? $urandom_range(MAX - 2, MAX + 2) : $urandom_range(0, 12);
      l   = ($urandom_range(0, 9) == 0) ? $urandom_range(MAX - 2, MAX + 3) : $urandom_range(1, 12);
      measure(gap, pre, d, l, 1);
    end

    din = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pulse_meas.md
Name: pulse_meas

Overview:
- Receiver-side counterpart of the team's one-shot pulse generator.
- After being armed, measures two values on a single-bit input: the delay from arm to the pulse rising edge, and the pulse width, both in clk cycles.
- Reports both counts with a one-cycle valid strobe. Used in benches and on-chip self-test to check generator delay/length settings, and to measure pulses arriving over a clock-domain crossing.

Parameters:
- width, 8, bit width of the delay and length counters and outputs; counters saturate at 2^width-1.

Ports:
- clk  input  1  clock; all sampling on posedge.
- rstn  input  1  asynchronous, active-low reset.
- arm  input  1  start a measurement; accepted only in IDLE.
- din  input  1  pulse to measure (active high).
- busy  output  1  high in WAIT_RISE and HIGH.
- valid  output  1  one-cycle strobe; dly_out, len_out and timeout are valid while it is high.
- dly_out  output  width  low samples counted before the first high sample.
- len_out  output  width  high samples counted in the pulse.
- timeout  output  1  measurement ended because the delay counter saturated.

Behaviour:
- Sample point s:
  - Equals din directly, or the synchronized din when PULSE_MEAS_SYNC_EN is defined.
  - "Edge N" means the N-th posedge after arm acceptance; edge 0 is the accepting edge.
- Reset, asynchronous:
  - State goes to IDLE.
  - busy=0, valid=0, timeout=0, dly_out=0, len_out=0.
  - Internal counters and synchronizer flops clear to 0.
  - A reset mid-measurement discards it with no valid strobe.
- IDLE:
  - arm=1 at an edge -> WAIT_RISE, dly counter cleared to 0, len counter cleared to 0, busy=1 after that edge.
  - Otherwise IDLE.
  - s is not sampled at edge 0.
- WAIT_RISE, evaluated at edges 1, 2, ...:
  - s=0 and dly counter < max -> dly counter +1.
  - s=0 and dly counter == max -> go to IDLE; after the edge: valid=1, timeout=1, dly_out=max, len_out=0.
  - s=1 -> HIGH, len counter = 1.
  - A din already high at arm gives dly_out=0.
- HIGH:
  - s=1 -> len counter +1, saturating at max. The block keeps waiting and never times out in HIGH.
  - s=0 -> IDLE; after this edge: valid=1, timeout=0, dly_out=dly counter, len_out=len counter.
- Output registers and strobes:
  - valid is high for exactly one cycle, then returns to 0.
  - dly_out, len_out and timeout hold their values until the next valid strobe or reset.
  - timeout clears on the next non-timeout strobe.
- arm handling:
  - arm while busy=1 is ignored; no queuing.
  - arm in the same cycle valid=1 (state IDLE) is accepted, giving back-to-back measurements.
- Arithmetic: unsigned; counters never wrap.

Optional Feature:
- Macro: PULSE_MEAS_SYNC_EN.
- Defined:
  - din passes through a 2-flop synchronizer (reset 0) clocked by clk; s is the second flop output.
  - Adds exactly 2 cycles to dly_out; len_out is unchanged for pulses ≥1 cycle wide in clk terms.
  - din may be asynchronous to clk.
- Undefined:
  - s = din, with no added latency.
  - din must be synchronous to clk.

Test Plan:
- No macro, width=8:
  - arm at edge 0; din low for edges 1-5, high for edges 6-8, low at edge 9.
  - Expect valid=1 for one cycle after edge 9, dly_out=5, len_out=3, timeout=0, busy=0 after edge 9.
- Same stimulus with PULSE_MEAS_SYNC_EN defined -> dly_out=7, len_out=3.
- No macro; din held high before arm and released after 4 samples -> dly_out=0, len_out=4.
- No macro, width=4; din never rises -> valid with timeout=1, dly_out=15, len_out=0 after edge 16.
- No macro, width=4; din high 20 samples -> len_out=15 (saturated), timeout=0.
- No macro; arm pulsed again during HIGH is ignored (single valid strobe). Then rstn pulsed low mid-WAIT_RISE -> all outputs 0, no valid, and a new arm is accepted normally.
